// File: rtl/c7bifu_iq.sv
// Instruction queue between fetch return and decode: circular FIFO of {pc, inst}.
// Optional same-cycle bypass through an empty queue when C7BIFU_IQ_BYPASS_EN is defined.
module c7bifu_iq #(
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2,
  parameter int AFULL_LVL = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall,
  input  logic        fch_vld,
  input  logic [31:0] fch_addr,
  input  logic [31:0] fch_inst,
  output logic        iq_rdy,
  output logic        fch_afull,
  output logic        inst_vld_f,
  output logic [31:0] inst_addr_f,
  output logic [31:0] inst_f,
  output logic        iq_empty
);

  localparam logic [PTR_W:0] CNT_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_AFULL = (PTR_W+1)'(AFULL_LVL);

  logic [DEPTH-1:0][31:0] addr_q, inst_q;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         cnt_q, cnt_d;

  logic empty, full, byp, push, pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_FULL);

`ifdef C7BIFU_IQ_BYPASS_EN
  // Empty queue and decode free: hand the fetch straight through, nothing stored.
  assign byp = empty & fch_vld & ~stall & ~flush;
`else
  assign byp = 1'b0;
`endif

  assign push = fch_vld & ~full & ~flush & ~byp;
  assign pop  = ~empty & ~stall & ~flush;

  assign iq_rdy     = ~full;
  assign fch_afull  = (cnt_q >= CNT_AFULL);
  assign iq_empty   = empty;
  assign inst_vld_f = pop | byp;

`ifdef C7BIFU_IQ_BYPASS_EN
  assign inst_addr_f = byp ? fch_addr : addr_q[rd_ptr_q];
  assign inst_f      = byp ? fch_inst : inst_q[rd_ptr_q];
`else
  assign inst_addr_f = addr_q[rd_ptr_q];
  assign inst_f      = inst_q[rd_ptr_q];
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is never cleared; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= fch_addr;
      inst_q[wr_ptr_q] <= fch_inst;
    end
  end

endmodule

// File: tb/tb_c7bifu_iq.sv
// Self-checking bench for c7bifu_iq: directed scenarios plus random traffic vs a queue model.
module tb_c7bifu_iq;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
`ifdef C7BIFU_IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, stall, fch_vld;
  logic [31:0] fch_addr, fch_inst;
  logic        iq_rdy, fch_afull, inst_vld_f, iq_empty;
  logic [31:0] inst_addr_f, inst_f;

  c7bifu_iq #(.DEPTH(DEPTH), .PTR_W(2), .AFULL_LVL(AFULL)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .fch_vld(fch_vld), .fch_addr(fch_addr), .fch_inst(fch_inst),
    .iq_rdy(iq_rdy), .fch_afull(fch_afull), .inst_vld_f(inst_vld_f),
    .inst_addr_f(inst_addr_f), .inst_f(inst_f), .iq_empty(iq_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] a; logic [31:0] i; } ent_t;
  ent_t        mq[$];
  logic [31:0] act_pc[$];
  int          checks = 0;
  int          errors = 0;
  logic        obs_vld, obs_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check mid-cycle against the model, advance the model, step.
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] ins,
                     input logic st, input logic fl, output logic accepted);
    int   n;
    logic byp, ev;
    fch_vld = v; fch_addr = a; fch_inst = ins; stall = st; flush = fl;
    #4;
    n   = mq.size();
    byp = BYP && n == 0 && v && !st && !fl;
    ev  = (n != 0 && !st && !fl) || byp;
    obs_vld = inst_vld_f;
    obs_rdy = iq_rdy;
    chk("inst_vld_f", {31'b0, inst_vld_f}, {31'b0, ev});
    chk("iq_rdy",     {31'b0, iq_rdy},     {31'b0, n != DEPTH});
    chk("iq_empty",   {31'b0, iq_empty},   {31'b0, n == 0});
    chk("fch_afull",  {31'b0, fch_afull},  {31'b0, n >= AFULL});
    if (ev) begin
      chk("inst_addr_f", inst_addr_f, byp ? a : mq[0].a);
      chk("inst_f",      inst_f,      byp ? ins : mq[0].i);
    end
    if (inst_vld_f) act_pc.push_back(inst_addr_f);
    accepted = v && !fl && (n != DEPTH);
    if (fl) mq.delete();
    else begin
      if (ev && !byp) void'(mq.pop_front());
      if (accepted && !byp) mq.push_back('{a: a, i: ins});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic        acc, hold, v, st, fl;
    logic [31:0] pc, ins;
    reset = 1'b1; flush = 1'b0; stall = 1'b0; fch_vld = 1'b0;
    fch_addr = '0; fch_inst = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_vld",   {31'b0, inst_vld_f}, 32'd0);
    chk("rst_rdy",   {31'b0, iq_rdy},     32'd1);
    chk("rst_empty", {31'b0, iq_empty},   32'd1);
    chk("rst_afull", {31'b0, fch_afull},  32'd0);

    // Fill under stall, then drain in order
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 32'h1c000000 + 32'(4*k), $urandom, 1'b1, 1'b0, acc);
      if (k == 2) chk("afull_after3", {31'b0, fch_afull}, 32'd1);
      if (k == 3) chk("rdy_after4",   {31'b0, iq_rdy},    32'd0);
    end
    act_pc.delete();
    for (int k = 0; k < 4; k++) cyc(1'b0, '0, '0, 1'b0, 1'b0, acc);
    chk("drain_empty", {31'b0, iq_empty}, 32'd1);
    chk("drain_cnt", act_pc.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      chk("drain_order", act_pc[k], 32'h1c000000 + 32'(4*k));

    // Streaming push+pop
    for (int k = 0; k < 10; k++)
      cyc(1'b1, 32'h1c000000 + 32'(4*k), $urandom, 1'b0, 1'b0, acc);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, acc);
    chk("stream_empty", {31'b0, iq_empty}, 32'd1);

    // Flush together with a fetch
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 32'h1c000020 + 32'(4*k), $urandom, 1'b1, 1'b0, acc);
    cyc(1'b1, 32'h1c000100, $urandom, 1'b0, 1'b1, acc);
    chk("flush_vld", {31'b0, obs_vld}, 32'd0);
    chk("flush_empty", {31'b0, iq_empty}, 32'd1);
    act_pc.delete();
    cyc(1'b1, 32'h1c000200, $urandom, 1'b0, 1'b0, acc);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, acc);
    chk("flush_first_cnt", act_pc.size(), 32'd1);
    chk("flush_first_pc", act_pc[0], 32'h1c000200);

    // Full queue with pop: held fetch accepted one cycle late, order across wrap
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 32'h1c000000 + 32'(4*k), $urandom, 1'b1, 1'b0, acc);
    act_pc.delete();
    ins = $urandom;
    cyc(1'b1, 32'h1c000010, ins, 1'b0, 1'b0, acc);
    chk("full_pop_rdy", {31'b0, obs_rdy}, 32'd0);
    cyc(1'b1, 32'h1c000010, ins, 1'b0, 1'b0, acc);
    chk("full_next_rdy", {31'b0, obs_rdy}, 32'd1);
    for (int k = 0; k < 5; k++) cyc(1'b0, '0, '0, 1'b0, 1'b0, acc);
    chk("wrap_cnt", act_pc.size(), 32'd5);
    for (int k = 0; k < 5; k++)
      chk("wrap_order", act_pc[k], 32'h1c000000 + 32'(4*k));

    // Random traffic; fetch holds an unaccepted request stable
    pc = 32'h1c001000; ins = $urandom; hold = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      v  = hold || ($urandom_range(0, 99) < 70);
      st = ($urandom_range(0, 99) < 20);
      fl = ($urandom_range(0, 99) < 2);
      cyc(v, pc, ins, st, fl, acc);
      if (fl) begin
        hold = 1'b0; pc = pc + 32'h100; ins = $urandom;
      end else if (acc) begin
        hold = 1'b0; pc = pc + 32'd4; ins = $urandom;
      end else hold = v;
    end
    for (int k = 0; k < 6; k++) cyc(1'b0, '0, '0, 1'b0, 1'b0, acc);
    chk("final_empty", {31'b0, iq_empty}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
